// File: rtl/lcd_cmd_sched.sv
// Command scheduler in front of the LCD SPI controller: auto power-up INITIAL,
// host/image round-robin, busy/error tracking with bounded retries and a sticky fault.
module lcd_cmd_sched #(
  parameter int COMM_WIDTH    = 3,
  parameter int LEVEL_WIDTH   = 12,
  parameter int IMG_THRESHOLD = 1024,
  parameter int ACK_TIMEOUT   = 16,
  parameter int MAX_RETRY     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_req,
  input  logic [COMM_WIDTH-1:0]  host_cmd,
  output logic                   host_ack,
  output logic                   host_rej,
  input  logic                   img_req,
  input  logic [LEVEL_WIDTH-1:0] fifo_level,
  output logic                   img_ack,
  output logic [COMM_WIDTH-1:0]  lcd_command,
  output logic                   lcd_valid,
  input  logic                   lcd_busy,
  input  logic                   lcd_error,
  output logic                   init_done,
  output logic                   fault,
  input  logic                   fault_clr,
  output logic [7:0]             err_count
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [COMM_WIDTH-1:0] CMD_INIT = COMM_WIDTH'(1);
  localparam logic [COMM_WIDTH-1:0] CMD_BLUE = COMM_WIDTH'(4);
  localparam logic [COMM_WIDTH-1:0] CMD_SHOW = COMM_WIDTH'(5);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, FAULT} state_t;
  typedef enum logic [1:0] {OWN_INIT, OWN_HOST, OWN_IMG} owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [COMM_WIDTH-1:0] cur_cmd_q, cur_cmd_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_flag_q, err_flag_d;
  logic                  init_pending_q, init_pending_d;
  logic                  last_img_q, last_img_d;
  logic                  host_ack_q, host_ack_d;
  logic                  host_rej_q, host_rej_d;
  logic                  img_ack_q, img_ack_d;
  logic                  lcd_valid_q, lcd_valid_d;
  logic                  init_done_q, init_done_d;
  logic                  fault_q, fault_d;
  logic [7:0]            err_count_q, err_count_d;

  logic host_legal, host_ok, img_ok, grant, fail;

  assign host_legal = (host_cmd >= CMD_INIT) && (host_cmd <= CMD_BLUE);
  // Only a re-init is accepted from the host until the panel is up.
  assign host_ok    = host_req && host_legal && (init_done_q || host_cmd == CMD_INIT);
  assign img_ok     = img_req && (fifo_level >= LEVEL_WIDTH'(IMG_THRESHOLD));

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cur_cmd_d      = cur_cmd_q;
    retry_d        = retry_q;
    tmo_d          = tmo_q;
    err_flag_d     = err_flag_q;
    init_pending_d = init_pending_q;
    last_img_d     = last_img_q;
    host_ack_d     = 1'b0;
    host_rej_d     = 1'b0;
    img_ack_d      = 1'b0;
    init_done_d    = init_done_q;
    fault_d        = fault_q;
    err_count_d    = err_count_q;
    grant          = 1'b0;
    fail           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (init_pending_q) begin
          cur_cmd_d   = CMD_INIT;
          owner_d     = OWN_INIT;
          init_done_d = 1'b0;
          grant       = 1'b1;
        end else if (host_req && !host_legal) begin
          host_rej_d = 1'b1;
        end else if (host_ok && (!img_ok || last_img_q)) begin
          cur_cmd_d  = host_cmd;
          owner_d    = OWN_HOST;
          last_img_d = 1'b0;
          grant      = 1'b1;
          if (host_cmd == CMD_INIT) init_done_d = 1'b0;
        end else if (img_ok) begin
          cur_cmd_d  = CMD_SHOW;
          owner_d    = OWN_IMG;
          last_img_d = 1'b1;
          grant      = 1'b1;
        end
        if (grant) begin
          state_d    = ISSUE;
          retry_d    = '0;
          err_flag_d = 1'b0;
        end
      end
      ISSUE: begin
        tmo_d   = TW'(1);
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (lcd_busy)                            state_d = WAIT_DONE;
        else if (tmo_q >= TW'(ACK_TIMEOUT - 1)) fail    = 1'b1;
        else                                     tmo_d   = tmo_q + 1'b1;
      end
      WAIT_DONE: begin
        err_flag_d = err_flag_q | lcd_error;
        if (!lcd_busy) begin
          if (err_flag_d) begin
            fail = 1'b1;
          end else begin
            state_d    = IDLE;
            retry_d    = '0;
            err_flag_d = 1'b0;
            unique case (owner_q)
              OWN_INIT: begin
                init_done_d    = 1'b1;
                init_pending_d = 1'b0;
              end
              OWN_HOST: begin
                host_ack_d = 1'b1;
                if (cur_cmd_q == CMD_INIT) init_done_d = 1'b1;
              end
              default: img_ack_d = 1'b1;
            endcase
          end
        end
      end
      FAULT: begin
        if (fault_clr) begin
          fault_d        = 1'b0;
          init_pending_d = 1'b1;
          init_done_d    = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A failed attempt is retried straight from ISSUE; exhausted retries park in FAULT.
    if (fail) begin
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      err_flag_d = 1'b0;
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + 1'b1;
        state_d = ISSUE;
      end else begin
        retry_d    = '0;
        state_d    = FAULT;
        fault_d    = 1'b1;
        host_rej_d = (owner_q == OWN_HOST);
      end
    end

    lcd_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_INIT;
      cur_cmd_q      <= '0;
      retry_q        <= '0;
      tmo_q          <= '0;
      err_flag_q     <= 1'b0;
      init_pending_q <= 1'b1;
      last_img_q     <= 1'b1;  // host wins the first contested grant
      host_ack_q     <= 1'b0;
      host_rej_q     <= 1'b0;
      img_ack_q      <= 1'b0;
      lcd_valid_q    <= 1'b0;
      init_done_q    <= 1'b0;
      fault_q        <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      cur_cmd_q      <= cur_cmd_d;
      retry_q        <= retry_d;
      tmo_q          <= tmo_d;
      err_flag_q     <= err_flag_d;
      init_pending_q <= init_pending_d;
      last_img_q     <= last_img_d;
      host_ack_q     <= host_ack_d;
      host_rej_q     <= host_rej_d;
      img_ack_q      <= img_ack_d;
      lcd_valid_q    <= lcd_valid_d;
      init_done_q    <= init_done_d;
      fault_q        <= fault_d;
      err_count_q    <= err_count_d;
    end
  end

  assign host_ack    = host_ack_q;
  assign host_rej    = host_rej_q;
  assign img_ack     = img_ack_q;
  assign lcd_command = cur_cmd_q;
  assign lcd_valid   = lcd_valid_q;
  assign init_done   = init_done_q;
  assign fault       = fault_q;
  assign err_count   = err_count_q;

endmodule
